serial_output: RTL and testbench

- Transmit-side endpoint for a 32-bit stb/ack output stream, such as the rs232_tx channel produced by a user design.
- Accepts one word per handshake and serialises bits [7:0] onto a UART line as 8N1, LSB first.
- Sits in the board top level between the user design's output channel and the board TX pin.
- Blocks the producer by holding ack low until the current frame has finished.

---
 rtl/serial_pkg.sv | 29 ++
 rtl/serial_baud_counter.sv | 42 ++++
 rtl/serial_output.sv | 123 ++++++++++++
 tb/tb_serial_output.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the UART serial transmit/receive endpoints.
package serial_pkg;

    // Clock cycles per UART bit at 100 MHz / 115200 baud.
    localparam int unsigned DEFAULT_CLOCKS_PER_BIT = 868;

    // 8N1 frame layout: one start bit, DATA_BITS data bits, STOP_BITS stop bits.
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    // Bit counter wide enough to index every data bit of a frame.
    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);

    // Word width of the stb/ack stream feeding the transmitter.
    localparam int unsigned STREAM_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } serial_state_e;

    // Width of a counter that must reach cpb-1; never narrower than one bit.
    function automatic int unsigned baud_cnt_width(input int unsigned cpb);
        return (cpb < 2) ? 1 : $clog2(cpb);
    endfunction

endpackage

// File: rtl/serial_baud_counter.sv
// Bit-period timer: counts clk cycles while enabled and pulses tick at
// count CLOCKS_PER_BIT-1, wrapping to zero on the same edge.
module serial_baud_counter
    import serial_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_c_o
);

    localparam int unsigned CNT_W = baud_cnt_width(CLOCKS_PER_BIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_max;

    // Next count: clear wins, otherwise advance and wrap at the end of a bit.
    always_comb begin
        at_max   = (count_q == CNT_W'(CLOCKS_PER_BIT - 1));
        tick_c_o = enable_i && at_max;
        count_d  = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = at_max ? '0 : count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_output.sv
// UART 8N1 transmitter sitting at the end of a 32-bit stb/ack stream.
// One word per handshake; bits [7:0] go out LSB first, the rest are dropped.
module serial_output
    import serial_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STREAM_W-1:0] in1,
    input  logic                in1_stb,
    output logic                in1_ack,
    output logic                tx,
    output logic                busy
);

    if (CLOCKS_PER_BIT < 2) begin : g_bad_cpb
        $error("serial_output: CLOCKS_PER_BIT must be at least 2");
    end

    serial_state_e          state_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic                   ack_q;
    logic                   busy_q;
    logic                   tx_q;

    logic                   baud_clear;
    logic                   baud_enable;
    logic                   bit_tick;
    logic                   unused_upper;

    // Only the low byte of each stream word is transmitted.
    assign unused_upper = ^in1[STREAM_W-1:DATA_BITS];

    // Bit timer runs for the whole frame and is held at zero while idle.
    assign baud_clear  = (state_q == ST_IDLE);
    assign baud_enable = (state_q != ST_IDLE);

    serial_baud_counter #(
        .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (baud_clear),
        .enable_i (baud_enable),
        .tick_c_o (bit_tick)
    );

    // Frame sequencer, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in1_stb && ack_q) begin
                        shift_q <= in1[DATA_BITS-1:0];
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end else begin
                        ack_q   <= 1'b1;
                        tx_q    <= 1'b1;
                    end
                end

                ST_START: begin
                    if (bit_tick) begin
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                            tx_q      <= 1'b1;
                            bit_cnt_q <= '0;
                            state_q   <= ST_STOP;
                        end else begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end

                ST_STOP: begin
                    if (bit_tick) begin
                        if (bit_cnt_q == BIT_CNT_W'(STOP_BITS - 1)) begin
                            ack_q     <= 1'b1;
                            busy_q    <= 1'b0;
                            bit_cnt_q <= '0;
                            state_q   <= ST_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in1_ack = ack_q;
    assign busy    = busy_q;
    assign tx      = tx_q;

endmodule

// File: tb/tb_serial_output.sv
// Randomised bench for serial_output against a frame-timing reference model.
module tb_serial_output;

    localparam int CPB = 4;
    localparam int FRAME_CYC = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in1 = '0;
    logic        in1_stb = 1'b0;
    logic        in1_ack;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    // Reference model: frame start edge, latched byte, expected ack/busy.
    bit       m_ack  = 1'b0;
    bit       m_busy = 1'b0;
    int       m_t    = 0;
    logic [7:0] m_data = '0;
    int       xfer_q[$];

    serial_output #(
        .CLOCKS_PER_BIT (CPB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in1     (in1),
        .in1_stb (in1_stb),
        .in1_ack (in1_ack),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Line level implied by position within the 10-bit frame.
    function automatic logic exp_tx();
        int idx;
        if (!m_busy) return 1'b1;
        idx = (edge_n - m_t) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_data[idx-1];
        return 1'b1;
    endfunction

    task automatic check_outputs();
        check_val("tx",   32'(tx),      32'(exp_tx()));
        check_val("ack",  32'(in1_ack), 32'(m_ack));
        check_val("busy", 32'(busy),    32'(m_busy));
    endtask

    // One clock edge: advance the model, then compare just after the edge.
    task automatic step(output bit xfer);
        bit pre;
        pre = in1_stb && in1_ack && !rst;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            m_ack  = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (edge_n == m_t + FRAME_CYC) begin
                m_busy = 1'b0;
                m_ack  = 1'b1;
            end
        end else if (in1_stb && m_ack) begin
            m_t    = edge_n;
            m_data = in1[7:0];
            m_busy = 1'b1;
            m_ack  = 1'b0;
        end else begin
            m_ack = 1'b1;
        end
        xfer = pre;
        if (pre) xfer_q.push_back(edge_n);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        bit x;
        for (int i = 0; i < n; i++) step(x);
    endtask

    // Present a word and hold stb until the handshake edge.
    task automatic send(input logic [31:0] word, input bit hold);
        bit x;
        bit got;
        got = 1'b0;
        in1     = word;
        in1_stb = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step(x);
            if (x) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_val("send_timeout", 32'(got), 32'd1);
        if (!hold) begin
            in1_stb = 1'b0;
            in1     = $urandom;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!m_busy && m_ack && !busy) begin
                done = 1'b1;
                break;
            end
            idle(1);
        end
        if (!done) check_val("idle_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_gap(input string tag);
        if (xfer_q.size() < 2) begin
            check_val(tag, 32'(xfer_q.size()), 32'd2);
        end else begin
            check_val(tag, 32'(xfer_q[$] - xfer_q[$-1]), 32'(FRAME_CYC + 1));
        end
    endtask

    initial begin
        logic [31:0] w;
        int n_before;

        // Reset applied and released.
        #1 rst = 1'b1;
        #1 check_outputs();
        idle(3);
        rst = 1'b0;
        idle(2);

        // Single frame and upper-bit masking.
        send(32'h0000_0048, 1'b0);
        wait_idle();
        check_val("frame_len", 32'(edge_n - xfer_q[$]), 32'(FRAME_CYC));
        send(32'hFFFF_FF55, 1'b0);
        wait_idle();
        idle(2);

        // Back-to-back with stb held continuously.
        send(32'h0000_0041, 1'b1);
        send(32'h0000_0042, 1'b0);
        check_gap("b2b_gap");
        wait_idle();

        // Backpressure: request arrives ten cycles into a frame.
        send(32'h0000_0044, 1'b0);
        idle(10);
        send(32'h0000_0043, 1'b0);
        check_gap("held_off_gap");
        wait_idle();

        // Stb raised then withdrawn during a frame: no transfer.
        send(32'h0000_0011, 1'b0);
        n_before = xfer_q.size();
        idle(5);
        in1_stb = 1'b1;
        in1     = $urandom;
        idle(8);
        in1_stb = 1'b0;
        wait_idle();
        check_val("no_xfer_on_drop", 32'(xfer_q.size()), 32'(n_before));

        // Randomised words, gaps and holds.
        for (int k = 0; k < 12; k++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                send(w, 1'b1);
            end else begin
                send(w, 1'b0);
                idle($urandom_range(0, 3));
            end
        end
        in1_stb = 1'b0;
        wait_idle();

        // Reset during data bit 3, then a clean frame.
        send($urandom, 1'b0);
        idle(4 * CPB + 1);
        #2 rst = 1'b1;
        #1;
        m_ack  = 1'b0;
        m_busy = 1'b0;
        check_outputs();
        idle(2);
        rst = 1'b0;
        send(32'h0000_005A, 1'b0);
        wait_idle();
        check_val("post_reset_len", 32'(edge_n - xfer_q[$]), 32'(FRAME_CYC));
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
